// File: rtl/fir_ctrl_sequencer.sv
// Control front end for the transposed FIR: sample-rate divider, input capture,
// datapath enables and a double-buffered coefficient bank with sample-aligned commit.
module fir_ctrl_sequencer #(
    parameter int unsigned DIV   = 40,
    parameter int unsigned NCOEF = 12
) (
    input  logic                   iClk_12M,
    input  logic                   iRst,
    input  logic                   iStart,
    input  logic                   iLoadReq,
    input  logic                   iCoeffWr,
    input  logic [3:0]             iCoeffAddr,
    input  logic [15:0]            iCoeffData,
    input  logic                   iCommit,
    input  logic [2:0]             iFirIn,
    output logic                   oEnSample_300k,
    output logic [3:0]             oEnMul,
    output logic                   oEnAdd,
    output logic                   oEnAcc,
    output logic [2:0]             oFirIn,
    output logic [16*NCOEF-1:0]    oCoeffBus,
    output logic [1:0]             oState,
    output logic                   oWrErr
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CntLast = CW'(DIV - 1);
    localparam logic [CW-1:0] CntCap  = CW'(DIV - 2);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StLoad = 2'd2,
        StPend = 2'd3
    } state_e;

    state_e                  r_state;
    state_e                  w_state_nxt;
    logic [CW-1:0]           rCnt;
    logic                    r_strobe;
    logic                    r_en;
    logic [2:0]              r_fir;
    logic                    r_wrerr;
    logic [NCOEF-1:0][15:0]  r_active;
    logic [NCOEF-1:0][15:0]  r_shadow;

    logic                    w_addr_ok;
    logic                    w_wr_ok;
    logic                    w_load_entry;
    logic                    w_swap;

    // Free-running divider; r_strobe is pre-decoded so it lines up with rCnt == DIV-1.
    always_ff @(posedge iClk_12M) begin
        if (iRst) begin
            rCnt     <= '0;
            r_strobe <= 1'b0;
        end else begin
            rCnt     <= (rCnt == CntLast) ? '0 : rCnt + 1'b1;
            r_strobe <= (rCnt == CntCap);
        end
    end

    always_ff @(posedge iClk_12M) begin
        if (iRst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            StIdle: begin
                if (iLoadReq) begin
                    w_state_nxt = StLoad;
                end else if (iStart) begin
                    w_state_nxt = StRun;
                end
            end
            StRun: begin
                if (iLoadReq) begin
                    w_state_nxt = StLoad;
                end
            end
            StLoad: begin
                if (iCommit) begin
                    w_state_nxt = StPend;
                end
            end
            StPend: begin
                if (r_strobe) begin
                    w_state_nxt = StRun;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    assign w_addr_ok    = (32'(iCoeffAddr) < NCOEF);
    assign w_wr_ok      = iCoeffWr && (r_state == StLoad) && w_addr_ok;
    assign w_load_entry = (r_state != StLoad) && (w_state_nxt == StLoad);
    assign w_swap       = (r_state == StPend) && r_strobe;

    // Shadow is seeded from the active set on LOAD entry so partial rewrites keep the rest.
    always_ff @(posedge iClk_12M) begin
        if (iRst) begin
            r_shadow <= '0;
            r_active <= '0;
        end else begin
            if (w_load_entry) begin
                r_shadow <= r_active;
            end else if (w_wr_ok) begin
                r_shadow[iCoeffAddr] <= iCoeffData;
            end
            if (w_swap) begin
                r_active <= r_shadow;
            end
        end
    end

    always_ff @(posedge iClk_12M) begin
        if (iRst) begin
            r_en    <= 1'b0;
            r_fir   <= 3'b000;
            r_wrerr <= 1'b0;
        end else begin
            r_en    <= (w_state_nxt != StIdle);
            r_wrerr <= iCoeffWr && !w_wr_ok;
            if (rCnt == CntCap) begin
                r_fir <= (r_state != StIdle) ? iFirIn : 3'b000;
            end
        end
    end

    assign oEnSample_300k = r_strobe;
    assign oEnMul         = {4{r_en}};
    assign oEnAdd         = r_en;
    assign oEnAcc         = r_en;
    assign oFirIn         = r_fir;
    assign oCoeffBus      = r_active;
    assign oState         = r_state;
    assign oWrErr         = r_wrerr;

endmodule

// File: tb/tb_fir_ctrl_sequencer.sv
// Randomised and directed bench for fir_ctrl_sequencer, checked against a
// sample-period level behavioural model of the control and coefficient rules.
module tb_fir_ctrl_sequencer;

    localparam int DIV   = 40;
    localparam int NCOEF = 12;

    logic          iClk_12M = 1'b0;
    logic          iRst = 1'b0;
    logic          iStart = 1'b0;
    logic          iLoadReq = 1'b0;
    logic          iCoeffWr = 1'b0;
    logic [3:0]    iCoeffAddr = '0;
    logic [15:0]   iCoeffData = '0;
    logic          iCommit = 1'b0;
    logic [2:0]    iFirIn = '0;
    logic          oEnSample_300k;
    logic [3:0]    oEnMul;
    logic          oEnAdd;
    logic          oEnAcc;
    logic [2:0]    oFirIn;
    logic [191:0]  oCoeffBus;
    logic [1:0]    oState;
    logic          oWrErr;

    fir_ctrl_sequencer #(
        .DIV   (DIV),
        .NCOEF (NCOEF)
    ) u_dut (
        .iClk_12M       (iClk_12M),
        .iRst           (iRst),
        .iStart         (iStart),
        .iLoadReq       (iLoadReq),
        .iCoeffWr       (iCoeffWr),
        .iCoeffAddr     (iCoeffAddr),
        .iCoeffData     (iCoeffData),
        .iCommit        (iCommit),
        .iFirIn         (iFirIn),
        .oEnSample_300k (oEnSample_300k),
        .oEnMul         (oEnMul),
        .oEnAdd         (oEnAdd),
        .oEnAcc         (oEnAcc),
        .oFirIn         (oFirIn),
        .oCoeffBus      (oCoeffBus),
        .oState         (oState),
        .oWrErr         (oWrErr)
    );

    always #5 iClk_12M = ~iClk_12M;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model: position within the sample period, mode, both coefficient sets.
    int          m_pos = 0;
    int          m_state = 0;
    logic [15:0] m_active [NCOEF];
    logic [15:0] m_shadow [NCOEF];
    logic [2:0]  m_fir = '0;
    logic        m_en = 1'b0;
    logic        m_wrerr = 1'b0;

    task automatic check_val(input string tag, input logic [191:0] got, input logic [191:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_edge();
        int  ns;
        bit  strobe_now;
        bit  wr_ok;
        if (iRst) begin
            m_pos   = 0;
            m_state = 0;
            m_fir   = '0;
            m_en    = 1'b0;
            m_wrerr = 1'b0;
            for (int k = 0; k < NCOEF; k++) begin
                m_active[k] = '0;
                m_shadow[k] = '0;
            end
            return;
        end
        strobe_now = (m_pos == DIV - 1);
        ns = m_state;
        case (m_state)
            0:       ns = iLoadReq ? 2 : (iStart ? 1 : 0);
            1:       ns = iLoadReq ? 2 : 1;
            2:       ns = iCommit ? 3 : 2;
            default: ns = strobe_now ? 1 : 3;
        endcase
        wr_ok   = iCoeffWr && (m_state == 2) && (int'(iCoeffAddr) < NCOEF);
        m_wrerr = iCoeffWr && !wr_ok;
        if (wr_ok) m_shadow[iCoeffAddr] = iCoeffData;
        if (m_state != 2 && ns == 2) m_shadow = m_active;
        if (m_state == 3 && strobe_now) m_active = m_shadow;
        if (m_pos == DIV - 2) m_fir = (m_state != 0) ? iFirIn : 3'b000;
        m_en    = (ns != 0);
        m_state = ns;
        m_pos   = (m_pos + 1) % DIV;
    endtask

    function automatic logic [191:0] model_bus();
        logic [191:0] b;
        b = '0;
        for (int k = 0; k < NCOEF; k++) b[16*k +: 16] = m_active[k];
        return b;
    endfunction

    task automatic step();
        @(posedge iClk_12M);
        model_edge();
        cyc++;
        #1;
        check_val("strobe", oEnSample_300k, (m_pos == DIV - 1));
        check_val("state", oState, m_state[1:0]);
        check_val("enables", {oEnMul, oEnAdd, oEnAcc}, m_en ? 6'h3f : 6'h00);
        check_val("firin", oFirIn, m_fir);
        check_val("wrerr", oWrErr, m_wrerr);
        check_val("coeffbus", oCoeffBus, model_bus());
    endtask

    task automatic clear_inputs();
        iRst     = 1'b0;
        iStart   = 1'b0;
        iLoadReq = 1'b0;
        iCoeffWr = 1'b0;
        iCommit  = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        iRst = 1'b1;
        step();
        step();
        iRst = 1'b0;
        cyc  = 0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d);
        iCoeffWr   = 1'b1;
        iCoeffAddr = a;
        iCoeffData = d;
    endtask

    int strobes;

    initial begin
        // Idle after reset: only the divider runs.
        do_reset();
        check_val("rst_state", oState, 2'd0);
        check_val("rst_bus", oCoeffBus, 192'd0);
        strobes = 0;
        while (cyc < 200) begin
            clear_inputs();
            iFirIn = 3'($urandom);
            step();
            if (oEnSample_300k) strobes++;
            if (cyc == 39 || cyc == 199) check_val("idle_strobe_at", oEnSample_300k, 1'b1);
        end
        check_val("idle_strobe_count", strobes, 5);

        // Directed walk through start, load, commit, rejected writes and reset in PEND.
        do_reset();
        while (cyc < 142) begin
            clear_inputs();
            iFirIn = 3'b101;
            case (cyc)
                5:        iStart = 1'b1;
                45, 100:  iLoadReq = 1'b1;
                46:       wr(4'd0, 16'h0123);
                47:       wr(4'd11, 16'hFFFE);
                48:       wr(4'd12, 16'h1234);
                50:       iCommit = 1'b1;
                90:       wr(4'd3, 16'h5555);
                101: begin
                    wr(4'd5, 16'h7FFF);
                    iCommit = 1'b1;
                end
                130:      iLoadReq = 1'b1;
                131:      wr(4'd0, 16'hAAAA);
                132:      iCommit = 1'b1;
                140, 141: iRst = 1'b1;
                default: ;
            endcase
            step();
            if (cyc == 6)   check_val("tp_en_on", oEnAdd, 1'b1);
            if (cyc == 39)  check_val("tp_firin", oFirIn, 3'b101);
            if (cyc == 79)  check_val("tp_bus_old", oCoeffBus, 192'd0);
            if (cyc == 80) begin
                check_val("tp_c0", oCoeffBus[15:0], 16'h0123);
                check_val("tp_c11", oCoeffBus[191:176], 16'hFFFE);
                check_val("tp_run", oState, 2'd1);
            end
            if (cyc == 49 || cyc == 91) check_val("tp_wrerr", oWrErr, 1'b1);
            if (cyc == 120) check_val("tp_c5", oCoeffBus[95:80], 16'h7FFF);
            if (cyc == 139) check_val("tp_pend", oState, 2'd3);
            if (cyc == 141) begin
                check_val("tp_rst_idle", oState, 2'd0);
                check_val("tp_rst_bus", oCoeffBus, 192'd0);
            end
        end
        cyc = 0;
        while (cyc < 100) begin
            clear_inputs();
            step();
            if (cyc == 38) check_val("tp_rel_nostrobe", oEnSample_300k, 1'b0);
            if (cyc == 39) check_val("tp_rel_strobe", oEnSample_300k, 1'b1);
        end
        check_val("tp_never_swapped", oCoeffBus, 192'd0);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            clear_inputs();
            iRst     = ($urandom_range(0, 999) == 0);
            iStart   = ($urandom_range(0, 99) < 5);
            iLoadReq = ($urandom_range(0, 99) < 3);
            iCommit  = ($urandom_range(0, 99) < 4);
            iFirIn   = 3'($urandom);
            if ($urandom_range(0, 99) < 25) wr(4'($urandom_range(0, 13)), 16'($urandom));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fir_ctrl_sequencer.md
# fir_ctrl_sequencer

Control and coefficient front end for the transposed FIR datapath.
- Divides the 12 MHz clock into the 300 kHz sample strobe.
- Captures the 3-bit input sample once per sample period.
- Drives the multiply/add/accumulate enables for the four 3-tap multiply-add slices.
- Supplies all 12 coefficients from a double-buffered register bank. A host can rewrite the bank while the filter runs; the new set takes effect atomically on a sample boundary.

## Interface
Parameters:
- DIV, 40, clock cycles per sample period (12 MHz / 300 kHz).
- NCOEF, 12, number of coefficients (4 slices × 3 taps).

Ports:
- iClk_12M  in  1  system clock, 12 MHz; the only clock.
- iRst  in  1  reset, synchronous and active-high.
- iStart  in  1  pulse; IDLE → RUN.
- iLoadReq  in  1  pulse; IDLE/RUN → LOAD.
- iCoeffWr  in  1  coefficient write strobe.
- iCoeffAddr  in  4  coefficient index, 0..11.
- iCoeffData  in  16  signed coefficient value.
- iCommit  in  1  pulse; LOAD → PEND.
- iFirIn  in  3  signed input sample from source.
- oEnSample_300k  out  1  one-cycle sample strobe.
- oEnMul  out  4  per-slice multiply enable.
- oEnAdd  out  1  adder enable.
- oEnAcc  out  1  accumulate enable.
- oFirIn  out  3  registered sample to datapath.
- oCoeffBus  out  192  active coefficients; coefficient k occupies bits [16k+15:16k].
- oState  out  2  IDLE=0, RUN=1, LOAD=2, PEND=3.
- oWrErr  out  1  one-cycle pulse on a rejected write.

## Operation
- Divider: rCnt counts 0..DIV-1 and wraps; it runs in every state. oEnSample_300k is registered and high exactly when rCnt == DIV-1.
- Sample capture: on the cycle rCnt == DIV-2, oFirIn <= iFirIn if the state is RUN/LOAD/PEND, otherwise oFirIn <= 0. oFirIn is therefore stable throughout the strobe cycle.
- Enables: oEnMul = 4'b1111, oEnAdd = 1, oEnAcc = 1 while the state is RUN, LOAD or PEND. All three are 0 in IDLE. They are registered and change with oState.
- Coefficient banks: active bank (12×16) and shadow bank (12×16). oCoeffBus always reflects the active bank.
- State machine:
  - IDLE: iStart → RUN; iLoadReq → LOAD (iLoadReq has priority if both are asserted).
  - RUN: iLoadReq → LOAD; iStart is ignored.
  - LOAD: shadow <= active on entry, in the same edge as the transition. iCoeffWr with addr < NCOEF writes shadow[addr]. iCommit → PEND.
  - PEND: waits for the strobe. In the cycle where oEnSample_300k = 1: active <= shadow, next state RUN. The new coefficients are visible on oCoeffBus the cycle after the strobe, so the datapath uses the old set for that strobe.
- Write rules:
  - iCoeffWr outside LOAD, or with addr ≥ NCOEF: no write, oWrErr pulses the next cycle.
  - iCoeffWr and iCommit in the same cycle: the write lands in shadow and is included in the committed set.
  - iLoadReq in LOAD or PEND: ignored.
- Arithmetic: none beyond the counter; coefficients pass through unmodified (signed, 16 bit).

## Timing
- Reset (iRst = 1 at an edge): rCnt = 0, state IDLE, both banks = 0, oEnSample_300k = 0, oEnMul = 0, oEnAdd = 0, oEnAcc = 0, oFirIn = 0, oCoeffBus = 0, oState = 0, oWrErr = 0.
- Cycle 0 is the first cycle after iRst deasserts (rCnt = 0). Strobes fall in cycles 39, 79, 119, …
- Reset mid-operation, including in PEND or during a write: all state above returns to its reset value; the pending commit is lost; the divider restarts at 0.
- State-transition latency: one cycle from the request pulse to oState changing.
- Commit latency: between 1 and DIV cycles from iCommit to the strobe, plus one cycle to oCoeffBus.
- iCommit on the strobe cycle itself: enters PEND that cycle; the swap happens at the next strobe, DIV cycles later.

## Test plan
- Reset, then 200 cycles idle → oEnSample_300k high only in cycles 39, 79, 119, 159, 199; enables 0; oCoeffBus = 0; oFirIn = 0.
- iStart in cycle 5, iFirIn = 3'b101 held → enables high from cycle 6; oFirIn = -3 from cycle 39 (captured at rCnt == 38).
- iLoadReq, write addr 0 = 16'h0123 and addr 11 = 16'hFFFE, iCommit in cycle 50 → oCoeffBus unchanged through cycle 79; from cycle 80, bits [15:0] = 0123 and [191:176] = FFFE; oState returns to RUN.
- Write in RUN, and write addr 12 in LOAD → no bank change, oWrErr pulses once per rejected write.
- iCoeffWr addr 5 = 16'h7FFF together with iCommit → after the next strobe, coefficient 5 = 7FFF.
- iRst asserted while in PEND → active bank remains 0 and never swaps; state IDLE; next strobe 40 cycles after release.
